// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller covering memory freeze, branch/jump
//            redirects and load-use stalls, with saturating event counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl (
    input  logic        clkHZ,
    input  logic        rst,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic        idex_jump,
    input  logic        exmem_branch_taken,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_flush,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        REDIR  = 2'd2
    } state_t;

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_stall_inc;
    logic        w_flush_inc;
    logic        w_load_use;

    assign w_load_use = idex_memread && (idex_rt != 5'd0) &&
                        ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    // The illegal encoding falls through the same path as RUN.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_flush  = 1'b0;
        w_next_state = RUN;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (mem_busy) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            w_next_state = FREEZE;
            w_stall_inc  = 1'b1;
        end else if (r_state == REDIR) begin
            ifid_flush = 1'b1;
        end else if (exmem_branch_taken) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_flush  = 1'b1;
            w_next_state = REDIR;
            w_flush_inc  = 1'b1;
        end else if (idex_jump) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            w_flush_inc = 1'b1;
        end else if (w_load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            w_stall_inc = 1'b1;
        end
    end

    always_ff @(posedge clkHZ) begin
        if (rst) begin
            r_state     <= RUN;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            r_state <= w_next_state;
            if (w_stall_inc && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_flush_inc && (r_flush_cnt != C_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl: event-level reference model
//            plus directed scenarios with literal expectations.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic        idex_jump;
    logic        exmem_branch_taken;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        ifid_uses_rt;
    logic        mem_busy;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        exmem_flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int n_pass  = 0;
    int n_total = 0;

    hazard_ctrl dut (
        .clkHZ              (clk),
        .rst                (rst),
        .idex_memread       (idex_memread),
        .idex_rt            (idex_rt),
        .idex_jump          (idex_jump),
        .exmem_branch_taken (exmem_branch_taken),
        .ifid_rs            (ifid_rs),
        .ifid_rt            (ifid_rt),
        .ifid_uses_rt       (ifid_uses_rt),
        .mem_busy           (mem_busy),
        .pc_write           (pc_write),
        .ifid_write         (ifid_write),
        .ifid_flush         (ifid_flush),
        .idex_bubble        (idex_bubble),
        .exmem_flush        (exmem_flush),
        .state              (state),
        .stall_cnt          (stall_cnt),
        .flush_cnt          (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    // Events in priority order; each maps to a fixed output vector.
    typedef enum int {EV_RST, EV_FRZ, EV_REDIR, EV_BR, EV_JMP, EV_STALL, EV_NONE} ev_t;

    int m_state = 0;
    int m_stall = 0;
    int m_flush = 0;
    bit m_valid = 1'b0;

    always @(negedge clk) begin
        ev_t ev;
        bit  lu;
        bit [4:0] exp_out;  // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush}
        lu = idex_memread && (int'(idex_rt) != 0) &&
             ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
        if (rst)                           ev = EV_RST;
        else if (mem_busy)                 ev = EV_FRZ;
        else if (m_valid && m_state == 2)  ev = EV_REDIR;
        else if (exmem_branch_taken)       ev = EV_BR;
        else if (idex_jump)                ev = EV_JMP;
        else if (lu)                       ev = EV_STALL;
        else                               ev = EV_NONE;

        case (ev)
            EV_RST:   exp_out = 5'b00111;
            EV_FRZ:   exp_out = 5'b00000;
            EV_REDIR: exp_out = 5'b11100;
            EV_BR:    exp_out = 5'b11111;
            EV_JMP:   exp_out = 5'b11110;
            EV_STALL: exp_out = 5'b00010;
            default:  exp_out = 5'b11000;
        endcase

        if (m_valid || rst) begin
            check("m_pc_write",    int'(pc_write),    int'(exp_out[4]));
            check("m_ifid_write",  int'(ifid_write),  int'(exp_out[3]));
            check("m_ifid_flush",  int'(ifid_flush),  int'(exp_out[2]));
            check("m_idex_bubble", int'(idex_bubble), int'(exp_out[1]));
            check("m_exmem_flush", int'(exmem_flush), int'(exp_out[0]));
        end
        if (m_valid) begin
            check("m_state",     int'(state),     m_state);
            check("m_stall_cnt", int'(stall_cnt), m_stall);
            check("m_flush_cnt", int'(flush_cnt), m_flush);
        end

        case (ev)
            EV_RST:   begin m_state = 0; m_stall = 0; m_flush = 0; m_valid = 1'b1; end
            EV_FRZ:   begin m_state = 1; m_stall = (m_stall < 65535) ? m_stall + 1 : 65535; end
            EV_BR:    begin m_state = 2; m_flush = (m_flush < 65535) ? m_flush + 1 : 65535; end
            EV_JMP:   begin m_state = 0; m_flush = (m_flush < 65535) ? m_flush + 1 : 65535; end
            EV_STALL: begin m_state = 0; m_stall = (m_stall < 65535) ? m_stall + 1 : 65535; end
            default:  m_state = 0;
        endcase
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input bit r, input bit mr, input int irt, input bit jp, input bit br,
                          input int rs, input int rt, input bit urt, input bit mb);
        rst                = r;
        idex_memread       = mr;
        idex_rt            = 5'(irt);
        idex_jump          = jp;
        exmem_branch_taken = br;
        ifid_rs            = 5'(rs);
        ifid_rt            = 5'(rt);
        ifid_uses_rt       = urt;
        mem_busy           = mb;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();
    endtask

    initial begin
        // Reset cycle outputs and post-reset state
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        mid();
        check("rst_pc_write",   int'(pc_write),    0);
        check("rst_ifid_write", int'(ifid_write),  0);
        check("rst_flushes",    int'({ifid_flush, idex_bubble, exmem_flush}), 7);
        adv();
        idle();
        mid();
        check("post_rst_state", int'(state),     0);
        check("post_rst_stall", int'(stall_cnt), 0);
        check("post_rst_flush", int'(flush_cnt), 0);
        check("post_rst_pcw",   int'(pc_write),  1);
        adv();

        // Load-use stall on rs
        set_in(0, 1, 5, 0, 0, 5, 0, 0, 0);
        mid();
        check("lu_writes", int'({pc_write, ifid_write}), 0);
        check("lu_bubble", int'(idex_bubble), 1);
        check("lu_stall0", int'(stall_cnt), 0);
        adv();
        idle();
        mid();
        check("lu_stall1", int'(stall_cnt), 1);
        check("lu_resume", int'(pc_write), 1);
        adv();

        // rt=0 never hazards
        do_reset();
        set_in(0, 1, 0, 0, 0, 0, 0, 1, 0);
        mid();
        check("rt0_pcw",    int'(pc_write), 1);
        check("rt0_bubble", int'(idex_bubble), 0);
        adv();
        idle();
        mid();
        check("rt0_stall", int'(stall_cnt), 0);
        adv();

        // Branch beats load-use, then a single REDIR cycle ignoring jump/load-use
        do_reset();
        set_in(0, 1, 5, 0, 1, 5, 0, 0, 0);
        mid();
        check("br_flushes", int'({ifid_flush, idex_bubble, exmem_flush}), 7);
        check("br_pcw",     int'(pc_write), 1);
        adv();
        set_in(0, 1, 5, 1, 0, 5, 0, 0, 0);
        mid();
        check("redir_state",   int'(state), 2);
        check("redir_flushes", int'({ifid_flush, idex_bubble, exmem_flush}), 4);
        check("redir_pcw",     int'(pc_write), 1);
        check("redir_fcnt",    int'(flush_cnt), 1);
        check("redir_scnt",    int'(stall_cnt), 0);
        adv();
        idle();
        mid();
        check("redir_exit", int'(state), 0);
        adv();

        // mem_busy for 3 cycles over a pending jump
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, 1, 0, 0, 0, 0, 1);
            mid();
            check("frz_writes", int'({pc_write, ifid_write}), 0);
            check("frz_state",  int'(state), (k == 0) ? 0 : 1);
            adv();
        end
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 0);
        mid();
        check("frz_jmp_state",   int'(state), 1);
        check("frz_jmp_flushes", int'({ifid_flush, idex_bubble, exmem_flush}), 6);
        check("frz_jmp_pcw",     int'(pc_write), 1);
        adv();
        idle();
        mid();
        check("frz_stall3", int'(stall_cnt), 3);
        check("frz_flush1", int'(flush_cnt), 1);
        check("frz_run",    int'(state), 0);
        adv();

        // Reset while frozen
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        adv();
        adv();
        mid();
        check("frz_pre_rst", int'(state), 1);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1);
        adv();
        idle();
        mid();
        check("rst_frz_state", int'(state), 0);
        check("rst_frz_cnts",  int'({stall_cnt, flush_cnt}), 0);
        adv();

        // Randomized traffic, checked by the model each cycle
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 63) == 0,
                   $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 3)),
                   $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0,
                   int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)),
                   $urandom_range(0, 1) == 1,
                   $urandom_range(0, 5) == 0);
            adv();
        end

        // Saturation of the stall counter
        do_reset();
        set_in(0, 1, 7, 0, 0, 0, 7, 1, 0);
        repeat (65535) adv();
        mid();
        check("sat_reach", int'(stall_cnt), 65535);
        adv();
        mid();
        check("sat_hold",  int'(stall_cnt), 65535);
        check("sat_flush", int'(flush_cnt), 0);
        adv();
        idle();
        adv();
        mid();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
